hms_clock: RTL and testbench



---
 rtl/hms_pkg.sv | 28 ++
 rtl/hms_clock_bcd_mod60.sv | 28 ++
 rtl/hms_clock.sv | 134 +++++++++++++
 tb/tb_hms_clock.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// rtl/hms_pkg.sv - shared state type, BCD limits and digit helpers for hms_clock
package hms_pkg;

   typedef enum logic {RUN, CHECK} hms_state_t;

   localparam logic [3:0] DIGIT_MAX   = 4'd9;
   localparam logic [3:0] TENS_MAX_MS = 4'd5;
   localparam logic [7:0] HH_MAX      = 8'h23;
   localparam logic [7:0] MS_MAX      = 8'h59;

   function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= DIGIT_MAX) && (v[3:0] <= DIGIT_MAX) && (v <= max);
   endfunction

   // Next value of a 00-59 BCD pair; nibbles never carry in binary.
   function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
      logic [7:0] r;
      r = v;
      if (v[3:0] >= DIGIT_MAX) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] >= TENS_MAX_MS) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hms_clock_bcd_mod60.sv
// rtl/hms_clock_bcd_mod60.sv - two-digit BCD 00-59 counter with load and at-59 flag
module bcd_mod60
   import hms_pkg::*;
#(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] q,
   output logic       max
);

   assign max = (q == MS_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= bcd_inc60(q);
      end
   end

endmodule

// File: rtl/hms_clock.sv
// rtl/hms_clock.sv - 24 h BCD wall clock with checked set port; alarm under HMS_CLOCK_ALARM_EN
module hms_clock
   import hms_pkg::*;
#(
   parameter logic [7:0] RESET_HH = 8'h00,
   parameter logic [7:0] RESET_MM = 8'h00,
   parameter logic [7:0] RESET_SS = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1s,
   input  logic       hold,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   output logic       set_err,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       carry_day
`ifdef HMS_CLOCK_ALARM_EN
   ,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_en,
   output logic       alarm_pulse
`endif
);

   hms_state_t state, state_next;
   logic       tick_prev;
   logic       tick_edge;
   logic       inc;
   logic       ss_max, mm_max;
   logic       set_ok;
   logic       load_time;
   logic [7:0] sh_hh, sh_mm, sh_ss;
   logic [7:0] hh_inc;

   assign tick_edge = tick_1s & ~tick_prev;
   assign inc       = tick_edge & ~hold & (state == RUN);
   assign set_ok    = bcd_valid(sh_hh, HH_MAX) && bcd_valid(sh_mm, MS_MAX) &&
                      bcd_valid(sh_ss, MS_MAX);
   assign load_time = (state == CHECK) && set_ok;

   always_comb begin
      state_next = state;
      set_ready  = 1'b0;
      case (state)
         RUN: begin
            set_ready = 1'b1;
            if (set_valid) state_next = CHECK;
         end
         CHECK: state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Hours: ones roll at 9, except 23 which wraps straight to 00.
   always_comb begin
      hh_inc = hh;
      if (hh == HH_MAX) begin
         hh_inc = 8'h00;
      end else if (hh[3:0] >= DIGIT_MAX) begin
         hh_inc = {hh[7:4] + 4'd1, 4'd0};
      end else begin
         hh_inc[3:0] = hh[3:0] + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= RUN;
         tick_prev <= 1'b1;
         set_err   <= 1'b0;
         carry_day <= 1'b0;
         hh        <= RESET_HH;
         sh_hh     <= 8'h00;
         sh_mm     <= 8'h00;
         sh_ss     <= 8'h00;
      end else begin
         state     <= state_next;
         tick_prev <= tick_1s;
         set_err   <= (state == CHECK) && !set_ok;
         carry_day <= inc && ss_max && mm_max && (hh == HH_MAX);
         if (state == RUN && set_valid) begin
            sh_hh <= set_hh;
            sh_mm <= set_mm;
            sh_ss <= set_ss;
         end
         if (load_time) begin
            hh <= sh_hh;
         end else if (inc && ss_max && mm_max) begin
            hh <= hh_inc;
         end
      end
   end

   bcd_mod60 #(.RESET_VAL(RESET_SS)) u_ss (
      .clk      (clk),
      .reset    (reset),
      .en       (inc),
      .load     (load_time),
      .load_val (sh_ss),
      .q        (ss),
      .max      (ss_max)
   );

   bcd_mod60 #(.RESET_VAL(RESET_MM)) u_mm (
      .clk      (clk),
      .reset    (reset),
      .en       (inc & ss_max),
      .load     (load_time),
      .load_val (sh_mm),
      .q        (mm),
      .max      (mm_max)
   );

`ifdef HMS_CLOCK_ALARM_EN
   // Only a counted advance into hh:mm:00 fires; a set load never does.
   always_ff @(posedge clk) begin
      if (!reset) begin
         alarm_pulse <= 1'b0;
      end else begin
         alarm_pulse <= alarm_en && inc && ss_max &&
                        (bcd_inc60(mm) == alarm_mm) &&
                        ((mm_max ? hh_inc : hh) == alarm_hh);
      end
   end
`endif

endmodule

// File: tb/tb_hms_clock.sv
// tb/tb_hms_clock.sv - table, hand sequences and random traffic against a seconds-of-day model
module tb_hms_clock;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1s = 1'b1;
   logic       hold = 1'b0;
   logic       set_valid = 1'b0;
   logic       set_ready;
   logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
   logic       set_err;
   logic [7:0] hh, mm, ss;
   logic       carry_day;
`ifdef HMS_CLOCK_ALARM_EN
   logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
   logic       alarm_en = 1'b0;
   logic       alarm_pulse;
`endif

   always #5 clk = ~clk;

   hms_clock dut (
      .clk       (clk),
      .reset     (reset),
      .tick_1s   (tick_1s),
      .hold      (hold),
      .set_valid (set_valid),
      .set_ready (set_ready),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .set_ss    (set_ss),
      .set_err   (set_err),
      .hh        (hh),
      .mm        (mm),
      .ss        (ss),
      .carry_day (carry_day)
`ifdef HMS_CLOCK_ALARM_EN
      ,
      .alarm_hh    (alarm_hh),
      .alarm_mm    (alarm_mm),
      .alarm_en    (alarm_en),
      .alarm_pulse (alarm_pulse)
`endif
   );

   int nvec = 0;
   int nbad = 0;

   // Model state: time as seconds of the day plus a pending set request.
   int          tsec = 0;
   bit          pend = 0;
   logic [23:0] pend_t = 24'h0;
   bit          mprev = 1;
   bit          exp_err = 0, exp_carry = 0;

   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic bit legal(input logic [23:0] t);
      bit ok;
      ok = 1;
      for (int i = 0; i < 6; i++) if (t[i*4 +: 4] > 4'd9) ok = 0;
      if (t[23:20] * 10 + t[19:16] > 23) ok = 0;
      if (t[15:12] * 10 + t[11:8] > 59) ok = 0;
      if (t[7:4] * 10 + t[3:0] > 59) ok = 0;
      return ok;
   endfunction

   function automatic int from_bcd(input logic [23:0] t);
      return (t[23:20] * 10 + t[19:16]) * 3600 + (t[15:12] * 10 + t[11:8]) * 60 +
             t[7:4] * 10 + t[3:0];
   endfunction

   // Advance the model for the coming edge, clock once, compare against the model.
   task automatic step();
      bit tedge;
      exp_err = 0; exp_carry = 0;
      if (!reset) begin
         tsec = 0; pend = 0; mprev = 1;
      end else begin
         tedge = tick_1s && !mprev;
         mprev = tick_1s;
         if (pend) begin
            pend = 0;
            if (legal(pend_t)) tsec = from_bcd(pend_t);
            else exp_err = 1;
         end else begin
            if (tedge && !hold) begin
               if (tsec == 86399) exp_carry = 1;
               tsec = (tsec + 1) % 86400;
            end
            if (set_valid) begin
               pend = 1; pend_t = {set_hh, set_mm, set_ss};
            end
         end
      end
      @(posedge clk); #1;
      nvec++;
      if ({hh, mm, ss} !== to_bcd(tsec) || set_ready !== !pend ||
          set_err !== exp_err || carry_day !== exp_carry) begin
         nbad++;
         $display("FAIL model vec%0d: got %h:%h:%h ready=%b err=%b carry=%b, want %h ready=%b err=%b carry=%b",
                  nvec, hh, mm, ss, set_ready, set_err, carry_day, to_bcd(tsec), !pend,
                  exp_err, exp_carry);
      end
   endtask

   typedef struct {
      logic        tick, hld, valid;
      logic [23:0] set_t, exp_t;
      logic        ready, err, carry;
   } vec_t;

   vec_t tbl[34];

   task automatic do_set(input logic [23:0] t);
      {set_hh, set_mm, set_ss} = t;
      set_valid = 1; step();
      set_valid = 0; step();
   endtask

   initial begin
      tbl = '{
         '{1,0,0,24'h000000,24'h000000,1,0,0}, '{0,0,0,24'h000000,24'h000000,1,0,0},
         '{0,0,1,24'h235958,24'h000000,0,0,0}, '{0,0,0,24'h000000,24'h235958,1,0,0},
         '{1,0,0,24'h000000,24'h235959,1,0,0}, '{1,0,0,24'h000000,24'h235959,1,0,0},
         '{0,0,0,24'h000000,24'h235959,1,0,0}, '{1,0,0,24'h000000,24'h000000,1,0,1},
         '{0,0,0,24'h000000,24'h000000,1,0,0}, '{0,0,1,24'h240000,24'h000000,0,0,0},
         '{0,0,0,24'h000000,24'h000000,1,1,0}, '{0,0,1,24'h005A00,24'h000000,0,0,0},
         '{0,0,0,24'h000000,24'h000000,1,1,0}, '{0,0,1,24'h000009,24'h000000,0,0,0},
         '{0,0,0,24'h000000,24'h000009,1,0,0}, '{1,0,0,24'h000000,24'h000010,1,0,0},
         '{1,0,0,24'h000000,24'h000010,1,0,0}, '{1,0,0,24'h000000,24'h000010,1,0,0},
         '{1,0,0,24'h000000,24'h000010,1,0,0}, '{1,0,0,24'h000000,24'h000010,1,0,0},
         '{0,0,0,24'h000000,24'h000010,1,0,0}, '{1,1,0,24'h000000,24'h000010,1,0,0},
         '{0,0,0,24'h000000,24'h000010,1,0,0}, '{0,0,1,24'h123456,24'h000010,0,0,0},
         '{1,0,0,24'h000000,24'h123456,1,0,0}, '{1,0,0,24'h000000,24'h123456,1,0,0},
         '{0,0,0,24'h000000,24'h123456,1,0,0}, '{1,0,0,24'h000000,24'h123457,1,0,0},
         '{0,0,0,24'h000000,24'h123457,1,0,0}, '{1,0,1,24'h010203,24'h123458,0,0,0},
         '{1,0,0,24'h000000,24'h010203,1,0,0}, '{0,1,1,24'h050607,24'h010203,0,0,0},
         '{0,1,0,24'h000000,24'h050607,1,0,0}, '{1,1,0,24'h000000,24'h050607,1,0,0}
      };

      @(posedge clk); #1;
      step(); step();
      reset = 1;

      for (int i = 0; i < 34; i++) begin
         tick_1s = tbl[i].tick; hold = tbl[i].hld; set_valid = tbl[i].valid;
         {set_hh, set_mm, set_ss} = tbl[i].set_t;
         step();
         nvec++;
         if ({hh, mm, ss} !== tbl[i].exp_t || set_ready !== tbl[i].ready ||
             set_err !== tbl[i].err || carry_day !== tbl[i].carry) begin
            nbad++;
            $display("FAIL table row%0d: got %h:%h:%h ready=%b err=%b carry=%b, want %h ready=%b err=%b carry=%b",
                     i, hh, mm, ss, set_ready, set_err, carry_day, tbl[i].exp_t,
                     tbl[i].ready, tbl[i].err, tbl[i].carry);
         end
      end
      hold = 0; set_valid = 0; tick_1s = 0;

      // Reset landing on the CHECK cycle must drop the set without an error.
      {set_hh, set_mm, set_ss} = 24'h990000;
      set_valid = 1; step();
      set_valid = 0; reset = 0; step();
      reset = 1; tick_1s = 0; step();

`ifdef HMS_CLOCK_ALARM_EN
      alarm_hh = 8'h07; alarm_mm = 8'h30;
      for (int r = 0; r < 2; r++) begin
         alarm_en = (r == 0);
         do_set(24'h072959);
         nvec++;
         if (alarm_pulse !== 1'b0) begin
            nbad++; $display("FAIL alarm on set: got %b want 0", alarm_pulse);
         end
         tick_1s = 0; step();
         tick_1s = 1; step();
         nvec++;
         if (alarm_pulse !== alarm_en) begin
            nbad++; $display("FAIL alarm pulse en=%b: got %b want %b", alarm_en, alarm_pulse, alarm_en);
         end
         tick_1s = 0; step();
         nvec++;
         if (alarm_pulse !== 1'b0) begin
            nbad++; $display("FAIL alarm width: got %b want 0", alarm_pulse);
         end
      end
      alarm_en = 0;
`endif

      for (int n = 0; n < 4000; n++) begin
         tick_1s   = ($urandom_range(0, 2) == 0) ? ~tick_1s : tick_1s;
         hold      = ($urandom_range(0, 9) == 0);
         set_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 2))
            0: {set_hh, set_mm, set_ss} = to_bcd($urandom_range(0, 86399));
            1: {set_hh, set_mm, set_ss} = to_bcd($urandom_range(86380, 86399));
            default: {set_hh, set_mm, set_ss} = 24'($urandom);
         endcase
         reset = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
